// File: rtl/peak_avg_meas_pkg.sv
// Shared definitions for the peak/average measurement block: state
// encoding and the default sample width and window size.
package peak_avg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_DW       = 16;
   localparam int DEF_WIN_LOG2 = 10;

endpackage

// File: rtl/peak_avg_meas_if.sv
// Handshake and result bundle between a measurement requester and
// peak_avg_meas. The requester drives start and the sample stream; the
// block returns status and the four window results.
interface peak_avg_meas_if
   import peak_avg_pkg::*;
#(
   parameter int DW = DEF_DW
);

   logic          start;
   logic [DW-1:0] data_in;
   logic          busy;
   logic          done;
   logic [DW-1:0] vmax;
   logic [DW-1:0] vmin;
   logic [DW-1:0] vpp;
   logic [DW-1:0] vavg;

   modport master (
      output start, data_in,
      input  busy, done, vmax, vmin, vpp, vavg
   );

   modport slave (
      input  start, data_in,
      output busy, done, vmax, vmin, vpp, vavg
   );

endinterface

// File: rtl/peak_avg_meas_sample_strobe.sv
// Sample-enable generator: strobe is high once every DIV clocks. A clr
// restarts the phase so that strobe is high in the very next cycle.
module sample_strobe
   import peak_avg_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic strobe
);

   localparam int             CW       = 16;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          strobe_r;

   // Next phase count: wrap at DIV-1, restart on clr.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clr) begin
         cnt_nxt_s = CNT_ZERO;
      end else if (cnt_r >= CNT_LAST) begin
         cnt_nxt_s = CNT_ZERO;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // Phase counter and registered strobe (high whenever the phase is zero).
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= CNT_ZERO;
         strobe_r <= 1'b0;
      end else begin
         cnt_r    <= cnt_nxt_s;
         strobe_r <= (cnt_nxt_s == CNT_ZERO);
      end
   end

   assign strobe = strobe_r;

endmodule

// File: rtl/peak_avg_meas.sv
// Windowed voltage measurement: over 2^WIN_LOG2 samples taken every DIV
// clocks, track max, min and sum, then publish max, min, peak-to-peak and
// truncated mean in a single done cycle. Results hold between windows.
module peak_avg_meas
   import peak_avg_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int WIN_LOG2 = DEF_WIN_LOG2,
   parameter int DIV      = 1
) (
   input logic             clk,
   input logic             rst,
   peak_avg_meas_if.slave  bus
);

   localparam int                   AW       = DW + WIN_LOG2;
   localparam logic [WIN_LOG2-1:0]  CNT_ONE  = WIN_LOG2'(1);
   localparam logic [WIN_LOG2-1:0]  CNT_ZERO = WIN_LOG2'(0);
   localparam logic [WIN_LOG2-1:0]  CNT_LAST = {WIN_LOG2{1'b1}};

   state_e              state_r;
   state_e              state_nxt_s;
   logic                start_acc_s;
   logic                strobe_s;
   logic                smp_s;
   logic                first_smp_s;
   logic                last_smp_s;

   logic [WIN_LOG2-1:0] smp_cnt_r;
   logic [AW-1:0]       acc_r;
   logic [AW-1:0]       acc_nxt_s;
   logic [DW-1:0]       max_r;
   logic [DW-1:0]       min_r;
   logic [DW-1:0]       max_nxt_s;
   logic [DW-1:0]       min_nxt_s;

   logic                busy_r;
   logic                done_r;
   logic [DW-1:0]       vmax_r;
   logic [DW-1:0]       vmin_r;
   logic [DW-1:0]       vpp_r;
   logic [DW-1:0]       vavg_r;

   sample_strobe #(
      .DIV (DIV)
   ) u_strobe (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_acc_s),
      .strobe (strobe_s)
   );

   // Sample qualification: a start only counts in IDLE, a sample only in ACQ.
   always_comb begin
      start_acc_s = 1'b0;
      smp_s       = 1'b0;
      if (state_r == IDLE) begin
         start_acc_s = bus.start;
      end else begin
         start_acc_s = 1'b0;
      end
      if (state_r == ACQ) begin
         smp_s = strobe_s;
      end else begin
         smp_s = 1'b0;
      end
   end

   assign first_smp_s = (smp_cnt_r == CNT_ZERO);
   assign last_smp_s  = (smp_cnt_r == CNT_LAST);

   // Next state: IDLE -> ACQ on start, ACQ -> DONE on the final sample, DONE lasts one cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = ACQ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACQ: begin
            if (smp_s && last_smp_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = ACQ;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Running extrema including the current sample; the first sample loads directly, ties keep the old value.
   always_comb begin
      max_nxt_s = max_r;
      min_nxt_s = min_r;
      acc_nxt_s = acc_r + {{WIN_LOG2{1'b0}}, bus.data_in};
      if (first_smp_s) begin
         max_nxt_s = bus.data_in;
         min_nxt_s = bus.data_in;
      end else begin
         if (bus.data_in > max_r) begin
            max_nxt_s = bus.data_in;
         end else begin
            max_nxt_s = max_r;
         end
         if (bus.data_in < min_r) begin
            min_nxt_s = bus.data_in;
         end else begin
            min_nxt_s = min_r;
         end
      end
   end

   // Window datapath: clear on accepted start, fold in each sample, publish on the final one.
   always_ff @(posedge clk) begin
      if (rst) begin
         smp_cnt_r <= CNT_ZERO;
         acc_r     <= {AW{1'b0}};
         max_r     <= {DW{1'b0}};
         min_r     <= {DW{1'b0}};
         vmax_r    <= {DW{1'b0}};
         vmin_r    <= {DW{1'b0}};
         vpp_r     <= {DW{1'b0}};
         vavg_r    <= {DW{1'b0}};
      end else if (start_acc_s) begin
         smp_cnt_r <= CNT_ZERO;
         acc_r     <= {AW{1'b0}};
      end else if (smp_s) begin
         smp_cnt_r <= smp_cnt_r + CNT_ONE;
         acc_r     <= acc_nxt_s;
         max_r     <= max_nxt_s;
         min_r     <= min_nxt_s;
         if (last_smp_s) begin
            // Both extrema come from this same window, so vpp never mixes windows.
            vmax_r <= max_nxt_s;
            vmin_r <= min_nxt_s;
            vpp_r  <= max_nxt_s - min_nxt_s;
            vavg_r <= acc_nxt_s[AW-1:WIN_LOG2];
         end
      end
   end

   // Status flags registered from the next state so they align with ACQ/DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != IDLE);
         done_r <= (state_nxt_s == DONE);
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.vmax = vmax_r;
   assign bus.vmin = vmin_r;
   assign bus.vpp  = vpp_r;
   assign bus.vavg = vavg_r;

endmodule

// File: tb/tb_peak_avg_meas.sv
// Directed bench for peak_avg_meas with a 4-sample window: one instance at
// DIV=1 for the table of windows and the control corner cases, one at
// DIV=3 for the sample-spacing case.
module tb_peak_avg_meas;
   import peak_avg_pkg::*;

   localparam int DW = 16;
   localparam int WL = 2;

   typedef struct {
      logic [3:0][15:0] d;
      logic [15:0]      emax;
      logic [15:0]      emin;
      logic [15:0]      epp;
      logic [15:0]      eavg;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs [6];

   always #10 clk = ~clk;

   peak_avg_meas_if #(.DW(DW)) b1 ();
   peak_avg_meas_if #(.DW(DW)) b3 ();

   peak_avg_meas #(.DW(DW), .WIN_LOG2(WL), .DIV(1)) dut1 (
      .clk (clk), .rst (rst), .bus (b1.slave)
   );
   peak_avg_meas #(.DW(DW), .WIN_LOG2(WL), .DIV(3)) dut3 (
      .clk (clk), .rst (rst), .bus (b3.slave)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_res1(input string tag, input logic [15:0] mx, input logic [15:0] mn,
                           input logic [15:0] pp, input logic [15:0] av);
      chk({tag, " vmax"}, {16'd0, b1.vmax}, {16'd0, mx});
      chk({tag, " vmin"}, {16'd0, b1.vmin}, {16'd0, mn});
      chk({tag, " vpp"},  {16'd0, b1.vpp},  {16'd0, pp});
      chk({tag, " vavg"}, {16'd0, b1.vavg}, {16'd0, av});
   endtask

   // One full window on the DIV=1 instance: start at cycle 0, samples at 1..4, done at 5.
   task automatic run_win1(input vec_t v, input string tag);
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         b1.data_in = v.d[i];
         chk({tag, " done low in ACQ"}, {31'd0, b1.done}, 32'd0);
         chk({tag, " busy in ACQ"}, {31'd0, b1.busy}, 32'd1);
         tick();
      end
      b1.data_in = 16'd0;
      chk({tag, " done at cycle 5"}, {31'd0, b1.done}, 32'd1);
      chk({tag, " busy in DONE"}, {31'd0, b1.busy}, 32'd1);
      chk_res1(tag, v.emax, v.emin, v.epp, v.eavg);
      tick();
      chk({tag, " done one cycle"}, {31'd0, b1.done}, 32'd0);
      chk({tag, " busy back low"}, {31'd0, b1.busy}, 32'd0);
   endtask

   initial begin
      logic [3:0][15:0] smp3;
      rst        = 1'b1;
      b1.start   = 1'b0;
      b1.data_in = 16'd0;
      b3.start   = 1'b0;
      b3.data_in = 16'd0;

      vecs[0] = '{d: {16'd50, 16'd200, 16'd300, 16'd100},
                  emax: 16'd300, emin: 16'd50, epp: 16'd250, eavg: 16'd162};
      vecs[1] = '{d: {16'd1000, 16'd1000, 16'd1000, 16'd1000},
                  emax: 16'd1000, emin: 16'd1000, epp: 16'd0, eavg: 16'd1000};
      vecs[2] = '{d: {16'd65535, 16'd65535, 16'd65535, 16'd65535},
                  emax: 16'd65535, emin: 16'd65535, epp: 16'd0, eavg: 16'd65535};
      vecs[3] = '{d: {16'd7, 16'd0, 16'd0, 16'd0},
                  emax: 16'd7, emin: 16'd0, epp: 16'd7, eavg: 16'd1};
      vecs[4] = '{d: {16'd5, 16'd9, 16'd9, 16'd5},
                  emax: 16'd9, emin: 16'd5, epp: 16'd4, eavg: 16'd7};
      vecs[5] = '{d: {16'd2, 16'd65535, 16'd1, 16'd40000},
                  emax: 16'd65535, emin: 16'd1, epp: 16'd65534, eavg: 16'd26384};

      // Reset, then idle: nothing moves.
      tick();
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         chk("idle done1", {31'd0, b1.done}, 32'd0);
         chk("idle busy1", {31'd0, b1.busy}, 32'd0);
         chk("idle done3", {31'd0, b3.done}, 32'd0);
         tick();
      end
      chk_res1("reset", 16'd0, 16'd0, 16'd0, 16'd0);

      // Table of windows.
      for (int k = 0; k < 6; k++) begin
         run_win1(vecs[k], $sformatf("vec%0d", k));
      end

      // DIV=3: samples only at cycles 1, 4, 7, 10; junk elsewhere must not matter.
      smp3 = {16'd40, 16'd30, 16'd20, 16'd10};
      b3.start = 1'b1;
      tick();
      b3.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if ((c % 3) == 1) begin
            b3.data_in = smp3[(c - 1) / 3];
         end else begin
            b3.data_in = ((c % 2) == 0) ? 16'd65535 : 16'd0;
         end
         chk($sformatf("div3 done low c%0d", c), {31'd0, b3.done}, 32'd0);
         chk($sformatf("div3 busy c%0d", c), {31'd0, b3.busy}, 32'd1);
         tick();
      end
      b3.data_in = 16'd0;
      chk("div3 done at 11", {31'd0, b3.done}, 32'd1);
      chk("div3 vmax", {16'd0, b3.vmax}, 32'd40);
      chk("div3 vmin", {16'd0, b3.vmin}, 32'd10);
      chk("div3 vpp",  {16'd0, b3.vpp},  32'd30);
      chk("div3 vavg", {16'd0, b3.vavg}, 32'd25);
      tick();
      chk("div3 done one cycle", {31'd0, b3.done}, 32'd0);

      // Starts during ACQ and DONE are ignored; a start right after DONE is taken.
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      b1.data_in = 16'd10;
      tick();
      b1.data_in = 16'd20;
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      b1.data_in = 16'd30;
      tick();
      b1.data_in = 16'd40;
      tick();
      chk("restart first done", {31'd0, b1.done}, 32'd1);
      chk_res1("restart first", 16'd40, 16'd10, 16'd30, 16'd25);
      b1.start = 1'b1;
      tick();
      chk("start in DONE ignored", {31'd0, b1.busy}, 32'd0);
      chk("idle after DONE", {31'd0, b1.done}, 32'd0);
      tick();
      b1.start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         b1.data_in = 16'(i);
         chk("second window done low", {31'd0, b1.done}, 32'd0);
         chk("first result held", {16'd0, b1.vmax}, 32'd40);
         tick();
      end
      chk("second done 5 later", {31'd0, b1.done}, 32'd1);
      chk_res1("restart second", 16'd4, 16'd1, 16'd3, 16'd2);
      tick();

      // Reset in the middle of a window aborts it.
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      b1.data_in = 16'd500;
      tick();
      b1.data_in = 16'd600;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", {31'd0, b1.busy}, 32'd0);
      chk("abort done", {31'd0, b1.done}, 32'd0);
      chk_res1("abort", 16'd0, 16'd0, 16'd0, 16'd0);
      for (int c = 0; c < 6; c++) begin
         chk("abort no done", {31'd0, b1.done}, 32'd0);
         tick();
      end
      run_win1(vecs[0], "after abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/peak_avg_meas.md
PEAK_AVG_MEAS -- requirements
Module: peak_avg_meas

Interface
REQ-001 Parameter DW, default 16: sample width in bits; unsigned mV value from the AD conversion stage.
REQ-002 Parameter WIN_LOG2, default 10: measurement window is 2^WIN_LOG2 samples.
REQ-003 Parameter DIV, default 1: one sample is taken every DIV clocks, legal range 1..65535.
REQ-004 clk  in  1  system clock (50 MHz), same clock as the AD conversion stage.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a new measurement window; sampled on clk.
REQ-007 data_in  in  DW  unsigned mV sample; the upstream stage updates it every clk.
REQ-008 busy  out  1  high from the first cycle after an accepted start through the done cycle.
REQ-009 done  out  1  one-cycle pulse when the result registers update.
REQ-010 vmax  out  DW  largest sample in the last completed window.
REQ-011 vmin  out  DW  smallest sample in the last completed window.
REQ-012 vpp  out  DW  vmax minus vmin, unsigned.
REQ-013 vavg  out  DW  window mean, truncated.

Function
REQ-014 The block SHALL implement states IDLE, ACQ and DONE.
REQ-015 State transitions SHALL be:
- IDLE to ACQ on start=1.
- ACQ to DONE on the clock that takes sample 2^WIN_LOG2.
- DONE to IDLE unconditionally after one cycle.
REQ-016 start SHALL be ignored while in ACQ or DONE; there is no queuing.
REQ-017 The divider counter SHALL clear on an accepted start. The first sample SHALL be taken on the first ACQ cycle, then every DIV clocks.
REQ-018 The first sample of a window SHALL load the running max and min directly. Each later sample SHALL update max when data_in > max and min when data_in < min. Equal values SHALL leave the running value unchanged.
REQ-019 The accumulator SHALL be DW+WIN_LOG2 bits, cleared on an accepted start, and SHALL never overflow.
REQ-020 vavg SHALL equal the accumulator shifted right by WIN_LOG2, with no rounding.
REQ-021 Latency: with DIV=1 and start at cycle 0, samples are taken at cycles 1..2^WIN_LOG2 and done, vmax, vmin, vpp and vavg are valid at cycle 2^WIN_LOG2+1.
REQ-022 In general, done SHALL assert 1+(2^WIN_LOG2-1)*DIV+1 cycles after the start cycle.
REQ-023 vmax, vmin, vpp and vavg SHALL update only in the DONE cycle and SHALL hold between windows.
REQ-024 vpp SHALL be computed from the final running max and min of the same window, never from mixed windows.
REQ-025 busy SHALL be 0 in IDLE and 1 in ACQ and DONE.
REQ-026 If start=1 in the DONE cycle, it SHALL be ignored. A start in the following IDLE cycle SHALL be accepted.

Reset
REQ-027 rst=1 SHALL force:
- the state to IDLE;
- busy, done, vmax, vmin, vpp and vavg to 0;
- the accumulator, sample counter and divider counter to 0.
REQ-028 rst asserted during ACQ SHALL abort the window, with no done pulse and all outputs at 0 on the next cycle.
REQ-029 rst SHALL have priority over start in the same cycle.

Structure
REQ-030 A shared package peak_avg_pkg SHALL hold:
- the state encoding (IDLE=0, ACQ=1, DONE=2, 2-bit);
- the default DW and WIN_LOG2 constants.
REQ-031 The DIV sample-enable counter SHALL be one sub-module, sample_strobe, with inputs clk, rst and clr, and a 1-bit strobe output.
REQ-032 The max/min/accumulate datapath and the state machine SHALL stay in peak_avg_meas.

Verification (WIN_LOG2=2, DIV=1 unless stated)
REQ-033 Reset then idle: done never pulses; all outputs read 0; busy=0.
REQ-034 start at cycle 0 with data 100, 300, 200, 50 at cycles 1..4 -> done at cycle 5 with vmax=300, vmin=50, vpp=250, vavg=162.
REQ-035 Constant data 1000 -> vmax=vmin=vavg=1000 and vpp=0.
REQ-036 DIV=3, start at cycle 0 -> samples taken at cycles 1, 4, 7, 10 only; done at cycle 11; values applied between sample cycles have no effect on the result.
REQ-037 Second start during ACQ and a start in the DONE cycle are both ignored; a start the cycle after DONE yields a second done exactly 5 cycles later; the first result holds until then.
REQ-038 rst pulse at cycle 2 of a window -> no done; outputs 0; a new start then completes normally.
REQ-039 DW=16, data 65535 for all samples -> vavg=65535 and vpp=0, with no accumulator overflow.
